brush_write_scheduler: RTL and testbench
========================================

// Module: brush_write_scheduler
// PURPOSE
//  Sole sequencer of the canvas frame_buffer BRAM write port. Converts cursor stamp requests
//  (from user_input) into a raster of square-brush pixel writes, clipped to the canvas.
//  Arbitrates those against a full-canvas clear sweep. Read/scan-out side is untouched.
// PARAMETERS
//  CANVAS_W  320  canvas width in pixels (x range 0..CANVAS_W-1)
//  CANVAS_H  180  canvas height in pixels (y range 0..CANVAS_H-1)
//  COLOR_W   4    palette-index width
//  ADDR_W    $clog2(CANVAS_W*CANVAS_H)  write-address width (16 at defaults)
// PORTS
//  clk_in           in   1        single clock (clk_pixel domain)
//  rst_in           in   1        reset, asynchronous, active-low
//  stamp_valid_in   in   1        stamp request valid
//  stamp_ready_out  out  1        stamp request accepted when valid&ready at clk_in edge
//  stamp_x_in       in   10       brush centre x
//  stamp_y_in       in   9        brush centre y
//  stamp_color_in   in   COLOR_W  brush colour
//  stamp_width_in   in   3        stroke width code w; brush side = w+1 (1..8)
//  clear_req_in     in   1        one-cycle pulse: wipe canvas
//  clear_color_in   in   COLOR_W  fill colour, sampled with clear_req_in
//  wr_en_out        out  1        write valid to frame_buffer
//  wr_addr_out      out  ADDR_W   y*CANVAS_W + x
//  wr_data_out      out  COLOR_W  pixel colour
//  wr_ready_in      in   1        frame_buffer accepts write this cycle
//  busy_out         out  1        high in any state but IDLE
// BEHAVIOUR
//  Clock/reset: one clock; reset is asynchronous and active-low.
//  Reset (rst_in=0): state IDLE, wr_en_out=0, wr_addr_out=0, wr_data_out=0, busy_out=0.
//    Also stamp_ready_out=0 while asserted, pending-clear=0, last-stamp register invalid.
//    Mid-operation reset aborts immediately; no further writes.
//  Write handshake: wr_* registered, held stable while wr_en_out & !wr_ready_in.
//    Advance only on wr_en_out & wr_ready_in. No skipped or duplicated pixel.
//  stamp_ready_out = (state==IDLE) & !pending_clear. Combinational from registers only.
//  FSM IDLE -> SETUP -> STAMP -> IDLE; IDLE -> CLEAR -> IDLE.
//  IDLE: pending clear has priority -> CLEAR. Else on stamp accept:
//    - Duplicate drop: if {x,y,color,width} equals last-stamp register and it is valid,
//      drop the stamp (zero writes, stay IDLE).
//    - Otherwise latch the request and go to SETUP.
//  SETUP (1 cycle): half=(w+1)>>1, signed 11b.
//    - Clip X range: x0=max(0,x-half), x1=min(CANVAS_W-1,x-half+w).
//    - Clip Y range: y0=max(0,y-half), y1=min(CANVAS_H-1,y-half+w).
//    - Register row_base=y0*CANVAS_W. The only multiply in the block.
//    - If x>=CANVAS_W or y>=CANVAS_H (empty rect): no writes, go to IDLE.
//  STAMP: raster x0..x1 inner, y0..y1 outer; row_base += CANVAS_W per row.
//    - wr_en_out=1 throughout. Accept at T -> first write presented at T+2.
//    - After last accepted write: update last-stamp register, go to IDLE.
//  CLEAR: addr 0..CANVAS_W*CANVAS_H-1 ascending, data=latched clear colour.
//    - After final accepted write: invalidate last-stamp register, go to IDLE.
//  clear_req_in in SETUP/STAMP: latched as pending; colour latched; taken after stamp completes.
//  clear_req_in in CLEAR: ignored (no restart). Colour unchanged.
//  clear_req_in and stamp_valid_in same cycle in IDLE: stamp_ready_out is high that cycle,
//    so the stamp is accepted; the clear is latched pending and runs next.
// STRUCTURE
//  Shared package canvas_pkg: CANVAS_W/H, COLOR_W, ADDR_W, stamp_t struct {x,y,color,width}.
//  One sub-module: brush_clip, the SETUP-stage bounds/row_base arithmetic.
// TESTING
//  1 Reset: hold rst_in=0 -> all outputs 0. Release -> stamp_ready_out=1, busy_out=0.
//  2 Stamp (10,20) w=2 color 5, wr_ready_in=1.
//    -> 9 writes, first at accept+2. Addrs 6089,6090,6091,6409,6410,6411,6729,6730,6731.
//    -> data 5; ready high the cycle after last write.
//  3 Corner stamp (0,0) w=3 -> exactly 4 writes: addrs 0,1,320,321.
//  4 Stall: wr_ready_in=0 for 5 cycles on 3rd write of test 2.
//    -> addr 6091 held; total 9 writes, no dup.
//  5 Clear pulse color 2 during stamp -> stamp completes, then 57600 writes.
//    -> addrs 0..57599, data 2. Repeat of prior stamp then rewrites (dedup invalidated).
//  6 Identical stamp twice -> second accepted with zero writes.
//    -> rst_in=0 mid-CLEAR -> wr_en_out=0 same cycle.

Source files
------------

// File: rtl/canvas_pkg.sv
// Shared canvas geometry, stamp request record and scheduler state encodings
// for the frame_buffer write-side logic.
package canvas_pkg;
  localparam int CANVAS_W = 320;
  localparam int CANVAS_H = 180;
  localparam int COLOR_W  = 4;
  localparam int ADDR_W   = $clog2(CANVAS_W * CANVAS_H);
  localparam int X_W      = 10;
  localparam int Y_W      = 9;
  localparam int WID_W    = 3;

  typedef struct packed {
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [COLOR_W-1:0] color;
    logic [WID_W-1:0]   width;
  } stamp_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_STAMP = 2'd2;
  localparam logic [1:0] ST_CLEAR = 2'd3;
endpackage

// File: rtl/brush_clip.sv
// Brush rectangle bounds for one stamp, clipped to the canvas, plus the
// frame_buffer address of the first clipped row.
module brush_clip
  import canvas_pkg::*;
(
  input  stamp_t              stamp_i,
  output logic [X_W-1:0]      x0_o,
  output logic [X_W-1:0]      x1_o,
  output logic [Y_W-1:0]      y0_o,
  output logic [Y_W-1:0]      y1_o,
  output logic [ADDR_W-1:0]   row_base_o,
  output logic                empty_o
);
  logic [3:0]  half;
  logic [10:0] xs;
  logic [10:0] xe;
  logic [9:0]  ys;
  logic [9:0]  ye;

  // Start/end edges are two's complement so a brush hanging off the
  // left/top edge yields a negative start that clamps to zero.
  always_comb begin
    half = 4'((4'(stamp_i.width) + 4'd1) >> 1);
    xs   = {1'b0, stamp_i.x} - {7'd0, half};
    xe   = xs + {8'd0, stamp_i.width};
    ys   = {1'b0, stamp_i.y} - {6'd0, half};
    ye   = ys + {7'd0, stamp_i.width};
    x0_o = xs[10] ? '0 : xs[9:0];
    x1_o = (xe > 11'(CANVAS_W - 1)) ? X_W'(CANVAS_W - 1) : xe[9:0];
    y0_o = ys[9] ? '0 : ys[8:0];
    y1_o = (ye > 10'(CANVAS_H - 1)) ? Y_W'(CANVAS_H - 1) : ye[8:0];
    row_base_o = ADDR_W'(y0_o) * ADDR_W'(CANVAS_W);
    empty_o = (stamp_i.x >= X_W'(CANVAS_W)) || (stamp_i.y >= Y_W'(CANVAS_H));
  end
endmodule

// File: rtl/brush_write_scheduler.sv
// Sole driver of the frame_buffer write port: rasterises clipped square brush
// stamps and runs full-canvas clear sweeps, with clears queued behind stamps.
module brush_write_scheduler
  import canvas_pkg::*;
(
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                stamp_valid_in,
  output logic                stamp_ready_out,
  input  logic [X_W-1:0]      stamp_x_in,
  input  logic [Y_W-1:0]      stamp_y_in,
  input  logic [COLOR_W-1:0]  stamp_color_in,
  input  logic [WID_W-1:0]    stamp_width_in,
  input  logic                clear_req_in,
  input  logic [COLOR_W-1:0]  clear_color_in,
  output logic                wr_en_out,
  output logic [ADDR_W-1:0]   wr_addr_out,
  output logic [COLOR_W-1:0]  wr_data_out,
  input  logic                wr_ready_in,
  output logic                busy_out,
  output logic [1:0]          dbg_state_out
);
  // Handshakes: a transfer happens on a clk_in edge where valid and ready are
  // both high; valid-side signals stay stable until then and ready never
  // depends combinationally on the matching valid.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CANVAS_W * CANVAS_H - 1);

  logic [1:0]         state_q, state_d;
  logic               run_q, run_d;
  stamp_t             req_q, req_d, last_q, last_d, stamp_in;
  logic               last_valid_q, last_valid_d;
  logic               pend_q, pend_d;
  logic [COLOR_W-1:0] clr_color_q, clr_color_d;
  logic [X_W-1:0]     x0_q, x0_d, x1_q, x1_d, x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d, y1_q, y1_d;
  logic [ADDR_W-1:0]  row_base_q, row_base_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [COLOR_W-1:0] wr_data_q, wr_data_d;

  logic [X_W-1:0]     c_x0, c_x1;
  logic [Y_W-1:0]     c_y0, c_y1;
  logic [ADDR_W-1:0]  c_row_base;
  logic               c_empty;
  logic               wr_fire, stamp_accept, stamp_dup;

  assign stamp_in        = {stamp_x_in, stamp_y_in, stamp_color_in, stamp_width_in};
  assign stamp_ready_out = run_q & (state_q == ST_IDLE) & ~pend_q;
  assign stamp_accept    = stamp_valid_in & stamp_ready_out;
  assign stamp_dup       = last_valid_q & (stamp_in == last_q);
  assign wr_fire         = wr_en_q & wr_ready_in;
  assign wr_en_out       = wr_en_q;
  assign wr_addr_out     = wr_addr_q;
  assign wr_data_out     = wr_data_q;
  assign busy_out        = (state_q != ST_IDLE);
  assign dbg_state_out   = state_q;

  brush_clip u_clip (
    .stamp_i    (req_q),
    .x0_o       (c_x0),
    .x1_o       (c_x1),
    .y0_o       (c_y0),
    .y1_o       (c_y1),
    .row_base_o (c_row_base),
    .empty_o    (c_empty)
  );

  always_comb begin
    state_d = state_q; run_d = 1'b1; req_d = req_q; last_d = last_q;
    last_valid_d = last_valid_q; pend_d = pend_q; clr_color_d = clr_color_q;
    x0_d = x0_q; x1_d = x1_q; x_d = x_q; y_d = y_q; y1_d = y1_q;
    row_base_d = row_base_q; wr_en_d = wr_en_q; wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (clear_req_in && state_q != ST_CLEAR) begin
      pend_d = 1'b1;
      clr_color_d = clear_color_in;
    end
    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          pend_d = 1'b0;
          wr_en_d = 1'b1;
          wr_addr_d = '0;
          wr_data_d = clr_color_d;
          state_d = ST_CLEAR;
        end else if (stamp_accept && !stamp_dup) begin
          req_d = stamp_in;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (c_empty) begin
          state_d = ST_IDLE;
        end else begin
          x0_d = c_x0; x1_d = c_x1; x_d = c_x0;
          y_d = c_y0; y1_d = c_y1;
          row_base_d = c_row_base;
          wr_en_d = 1'b1;
          wr_addr_d = c_row_base + ADDR_W'(c_x0);
          wr_data_d = req_q.color;
          state_d = ST_STAMP;
        end
      end
      ST_STAMP: begin
        if (wr_fire) begin
          if (x_q != x1_q) begin
            x_d = x_q + X_W'(1);
            wr_addr_d = wr_addr_q + ADDR_W'(1);
          end else if (y_q != y1_q) begin
            x_d = x0_q;
            y_d = y_q + Y_W'(1);
            row_base_d = row_base_q + ADDR_W'(CANVAS_W);
            wr_addr_d = row_base_q + ADDR_W'(CANVAS_W) + ADDR_W'(x0_q);
          end else begin
            wr_en_d = 1'b0;
            last_d = req_q;
            last_valid_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        if (wr_fire) begin
          if (wr_addr_q == LAST_ADDR) begin
            wr_en_d = 1'b0;
            last_valid_d = 1'b0;
            state_d = ST_IDLE;
          end else begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_IDLE; run_q <= 1'b0; req_q <= '0; last_q <= '0;
      last_valid_q <= 1'b0; pend_q <= 1'b0; clr_color_q <= '0;
      x0_q <= '0; x1_q <= '0; x_q <= '0; y_q <= '0; y1_q <= '0;
      row_base_q <= '0; wr_en_q <= 1'b0; wr_addr_q <= '0; wr_data_q <= '0;
    end else begin
      state_q <= state_d; run_q <= run_d; req_q <= req_d; last_q <= last_d;
      last_valid_q <= last_valid_d; pend_q <= pend_d; clr_color_q <= clr_color_d;
      x0_q <= x0_d; x1_q <= x1_d; x_q <= x_d; y_q <= y_d; y1_q <= y1_d;
      row_base_q <= row_base_d; wr_en_q <= wr_en_d; wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end
endmodule

// File: tb/tb_brush_write_scheduler.sv
// Directed bench for brush_write_scheduler: reference model fills an expected
// write queue, a write monitor pops and compares every accepted write.
module tb_brush_write_scheduler;
  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        stamp_valid_in;
  logic        stamp_ready_out;
  logic [9:0]  stamp_x_in;
  logic [8:0]  stamp_y_in;
  logic [3:0]  stamp_color_in;
  logic [2:0]  stamp_width_in;
  logic        clear_req_in;
  logic [3:0]  clear_color_in;
  logic        wr_en_out;
  logic [15:0] wr_addr_out;
  logic [3:0]  wr_data_out;
  logic        wr_ready_in;
  logic        busy_out;
  logic [1:0]  dbg_state_out;

  logic [19:0] exp_q[$];
  int n_chk  = 0;
  int n_fail = 0;
  int n_wr   = 0;

  brush_write_scheduler dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .stamp_valid_in(stamp_valid_in), .stamp_ready_out(stamp_ready_out),
    .stamp_x_in(stamp_x_in), .stamp_y_in(stamp_y_in),
    .stamp_color_in(stamp_color_in), .stamp_width_in(stamp_width_in),
    .clear_req_in(clear_req_in), .clear_color_in(clear_color_in),
    .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out),
    .wr_ready_in(wr_ready_in), .busy_out(busy_out), .dbg_state_out(dbg_state_out)
  );

  // clock
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // scoreboard: inputs are driven 2ns after posedge, so negedge sees a stable
  // handshake that the next posedge will accept
  always @(negedge clk_in) begin
    if (wr_en_out === 1'b1 && wr_ready_in === 1'b1) begin
      logic [19:0] e;
      n_wr++;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $error("FAIL spurious_write observed addr=%0d data=%0d expected no write",
               wr_addr_out, wr_data_out);
      end else begin
        e = exp_q.pop_front();
        assert ({wr_addr_out, wr_data_out} === e) else begin
          n_fail++;
          $error("FAIL write observed addr=%0d data=%0d expected addr=%0d data=%0d",
                 wr_addr_out, wr_data_out, e[19:4], e[3:0]);
        end
      end
    end
  end

  // reference model of one clipped stamp
  task automatic push_stamp(input int x, input int y, input int w, input int c);
    int half;
    half = (w + 1) / 2;
    if (x >= 320 || y >= 180) return;
    for (int yy = y - half; yy <= y - half + w; yy++)
      for (int xx = x - half; xx <= x - half + w; xx++)
        if (xx >= 0 && xx < 320 && yy >= 0 && yy < 180)
          exp_q.push_back({16'(yy * 320 + xx), 4'(c)});
  endtask

  task automatic push_clear(input int n, input int c);
    for (int a = 0; a < n; a++) exp_q.push_back({16'(a), 4'(c)});
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #2;
    end
  endtask

  task automatic send_stamp(input int x, input int y, input int w, input int c);
    stamp_valid_in = 1'b1;
    stamp_x_in = 10'(x); stamp_y_in = 9'(y);
    stamp_width_in = 3'(w); stamp_color_in = 4'(c);
    step(1);
    stamp_valid_in = 1'b0;
  endtask

  task automatic wait_writes(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (n_wr < target && k < budget) begin
      step(1);
      k++;
    end
    chk(tag, n_wr, target);
  endtask

  initial begin
    rst_in = 1'b0; stamp_valid_in = 1'b0; stamp_x_in = '0; stamp_y_in = '0;
    stamp_color_in = '0; stamp_width_in = '0; clear_req_in = 1'b0;
    clear_color_in = '0; wr_ready_in = 1'b1;

    // reset
    step(3);
    chk("rst_wr_en", wr_en_out, 0);
    chk("rst_wr_addr", wr_addr_out, 0);
    chk("rst_wr_data", wr_data_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_ready", stamp_ready_out, 0);
    rst_in = 1'b1;
    step(1);
    chk("post_rst_ready", stamp_ready_out, 1);
    chk("post_rst_busy", busy_out, 0);

    // basic 3x3 stamp with latency
    n_wr = 0;
    push_stamp(10, 20, 2, 5);
    send_stamp(10, 20, 2, 5);
    chk("setup_busy", busy_out, 1);
    chk("setup_no_write", wr_en_out, 0);
    step(1);
    chk("first_write_en", wr_en_out, 1);
    chk("first_write_addr", wr_addr_out, 6089);
    wait_writes(9, 40, "stamp_count");
    chk("ready_after_stamp", stamp_ready_out, 1);
    chk("en_low_after_stamp", wr_en_out, 0);

    // corner clipping
    n_wr = 0;
    push_stamp(0, 0, 3, 7);
    send_stamp(0, 0, 3, 7);
    wait_writes(4, 40, "corner_count");
    step(3);
    chk("corner_no_extra", n_wr, 4);

    // backpressure on the third write
    n_wr = 0;
    push_stamp(10, 20, 2, 5);
    send_stamp(10, 20, 2, 5);
    wait_writes(2, 40, "stall_pre");
    wr_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("stall_addr_held", wr_addr_out, 6091);
      chk("stall_en_held", wr_en_out, 1);
    end
    wr_ready_in = 1'b1;
    wait_writes(9, 40, "stall_count");
    step(3);
    chk("stall_no_dup", n_wr, 9);

    // bottom-right clip with widest brush
    n_wr = 0;
    push_stamp(319, 179, 7, 4);
    send_stamp(319, 179, 7, 4);
    wait_writes(25, 80, "br_clip_count");

    // centre outside canvas: no writes
    n_wr = 0;
    send_stamp(400, 10, 1, 1);
    chk("empty_setup_busy", busy_out, 1);
    step(1);
    chk("empty_back_idle", busy_out, 0);
    step(5);
    chk("empty_no_writes", n_wr, 0);

    // duplicate drop
    n_wr = 0;
    push_stamp(200, 100, 0, 9);
    send_stamp(200, 100, 0, 9);
    wait_writes(1, 20, "dedup_first");
    step(1);
    chk("dedup_ready", stamp_ready_out, 1);
    send_stamp(200, 100, 0, 9);
    chk("dedup_stay_idle", busy_out, 0);
    step(10);
    chk("dedup_no_writes", n_wr, 1);

    // clear requested during a stamp
    n_wr = 0;
    push_stamp(100, 50, 1, 3);
    push_clear(57600, 2);
    send_stamp(100, 50, 1, 3);
    clear_req_in = 1'b1; clear_color_in = 4'd2;
    step(1);
    clear_req_in = 1'b0; clear_color_in = 4'd0;
    chk("pending_blocks_ready", stamp_ready_out, 0);
    wait_writes(57604, 60000, "clear_count");
    chk("clear_done_busy", busy_out, 0);
    chk("clear_done_ready", stamp_ready_out, 1);
    n_wr = 0;
    push_stamp(100, 50, 1, 3);
    send_stamp(100, 50, 1, 3);
    wait_writes(4, 40, "rewrite_after_clear");
    step(1);
    send_stamp(100, 50, 1, 3);
    step(10);
    chk("dedup_after_rewrite", n_wr, 4);

    // stamp and clear together, then reset mid-clear
    n_wr = 0;
    push_stamp(5, 5, 0, 1);
    push_clear(200, 6);
    clear_req_in = 1'b1; clear_color_in = 4'd6;
    send_stamp(5, 5, 0, 1);
    clear_req_in = 1'b0;
    wait_writes(101, 400, "pre_reset_writes");
    rst_in = 1'b0;
    #1;
    chk("abort_wr_en", wr_en_out, 0);
    chk("abort_busy", busy_out, 0);
    chk("abort_ready", stamp_ready_out, 0);
    exp_q.delete();
    step(3);
    rst_in = 1'b1;
    step(1);
    chk("rerun_ready", stamp_ready_out, 1);
    step(5);
    chk("no_pending_after_reset", busy_out, 0);
    chk("no_writes_after_reset", n_wr, 101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
